code_nco_ctl: RTL and testbench

- Parametrised code NCO, next generation of the GPS C/A chip-rate generator used by the synthesizer and the receiver code-tracking loop.
- Phase accumulator carry-out advances a modulo-CODE_LEN chip counter, which addresses an external multi-code ROM.
- Adds the following over the previous block:
  - a registered frequency word with write strobe;
  - loadable chip index and fractional phase, for acquisition handover;
  - a code-epoch pulse and chip-edge strobe;
  - a chip index aligned with the code output;
  - configurable ROM latency;
  - an asynchronous active-low reset.

---
 rtl/code_nco_pkg.sv | 22 ++
 rtl/code_chip_counter.sv | 72 +++++++
 rtl/code_nco.sv | 160 ++++++++++++++++
 tb/tb_code_nco_ctl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/code_nco_pkg.sv
// code_nco_pkg
// Purpose: shared constants, default widths, the chip index type and the
//          modulo-N chip successor used by the code NCO and its bench model.
// Ports:   none (package).
package code_nco_pkg;

  localparam int CA_CODE_LEN  = 1023;  // GPS C/A chips per code period
  localparam int CA_NUM_SV    = 36;    // codes held side by side in the ROM word
  localparam int DEF_PHASE_W  = 32;
  localparam int DEF_ADDR_W   = 10;
  localparam int DEF_SEL_W    = 6;
  localparam int DEF_ROM_LAT  = 1;

  typedef logic [DEF_ADDR_W-1:0] chip_idx_t;

  // Successor of a chip index in a code of len chips (len-1 wraps to 0).
  function automatic int unsigned chip_wrap_next(input int unsigned idx,
                                                 input int unsigned len);
    return (idx >= len - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/code_chip_counter.sv
// code_chip_counter
// Purpose: modulo-CODE_LEN loadable chip counter. Advances on an accumulator
//          carry of a valid sample and flags each sample that starts a chip
//          (o_new_chip) or starts chip 0 (o_wrap).
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   i_dv          sample valid (stage-1)
//   i_carry       accumulator carry of that sample
//   i_load        load request (stage-1), overrides counting
//   i_load_chip   chip index to load (out-of-range values load 0)
//   o_chip        chip register (drives the ROM address)
//   o_new_chip    sample at o_chip is the first of its chip
//   o_wrap        sample at o_chip is the first of chip 0
module code_chip_counter
  import code_nco_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int CODE_LEN = CA_CODE_LEN
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_dv,
  input  logic              i_carry,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_chip,
  output logic [ADDR_W-1:0] o_chip,
  output logic              o_new_chip,
  output logic              o_wrap
);

  logic [ADDR_W-1:0] r_chip;
  logic              r_new;
  logic              r_wrap;
  logic              r_pend;       // load arrived on an invalid sample
  logic              r_pend_wrap;
  logic [ADDR_W-1:0] w_next;
  logic [ADDR_W-1:0] w_load_val;
  logic              w_at_end;

  assign w_at_end   = (32'(r_chip) == 32'(CODE_LEN - 1));
  assign w_next     = ADDR_W'(chip_wrap_next(32'(r_chip), 32'(CODE_LEN)));
  assign w_load_val = (32'(i_load_chip) >= 32'(CODE_LEN)) ? '0 : i_load_chip;

  // A load seen on an invalid sample still has to mark the next valid
  // sample as a chip start, so it is parked in r_pend until then.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_chip      <= '0;
      r_new       <= 1'b0;
      r_wrap      <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_wrap <= 1'b0;
    end else if (i_load) begin
      r_chip      <= w_load_val;
      r_new       <= 1'b1;
      r_wrap      <= (w_load_val == '0);
      r_pend      <= ~i_dv;
      r_pend_wrap <= (w_load_val == '0);
    end else if (i_dv) begin
      if (i_carry) r_chip <= w_next;
      r_new       <= i_carry | r_pend;
      r_wrap      <= i_carry ? w_at_end : (r_pend & r_pend_wrap);
      r_pend      <= 1'b0;
      r_pend_wrap <= 1'b0;
    end
  end

  assign o_chip     = r_chip;
  assign o_new_chip = r_new;
  assign o_wrap     = r_wrap;

endmodule

// File: rtl/code_nco.sv
// code_nco_ctl
// Purpose: code NCO. A phase accumulator driven by a registered frequency word
//          produces carries that advance a modulo-CODE_LEN chip counter; the
//          counter addresses an external multi-code ROM, and the selected code
//          bit is output together with its chip index, chip-edge and epoch
//          strobes, all aligned through a matching delay pipeline.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   dv_in         sample enable
//   freq, freq_we frequency word and its write strobe
//   load, load_chip, load_phase  acquisition handover load
//   code_sel      ROM bit (space vehicle) select
//   rom_addr      ROM address = chip counter
//   rom_data      ROM word, valid ROM_LAT cycles after rom_addr
//   dv_out, q, chip_idx, chip_edge, epoch  aligned outputs
module code_nco_ctl
  import code_nco_pkg::*;
#(
  parameter int PHASE_W   = DEF_PHASE_W,
  parameter int CODE_LEN  = CA_CODE_LEN,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int NUM_CODES = CA_NUM_SV,
  parameter int SEL_W     = DEF_SEL_W,
  parameter int ROM_LAT   = DEF_ROM_LAT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 dv_in,
  input  logic [PHASE_W-1:0]   freq,
  input  logic                 freq_we,
  input  logic                 load,
  input  logic [ADDR_W-1:0]    load_chip,
  input  logic [PHASE_W-1:0]   load_phase,
  input  logic [SEL_W-1:0]     code_sel,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [NUM_CODES-1:0] rom_data,
  output logic                 dv_out,
  output logic                 q,
  output logic [ADDR_W-1:0]    chip_idx,
  output logic                 chip_edge,
  output logic                 epoch
);

  logic [PHASE_W-1:0] r_freq;
  logic [PHASE_W-1:0] r_phase;
  logic               r_carry;
  logic               r_dv1;
  logic               r_load1;
  logic [ADDR_W-1:0]  r_load_chip1;
  logic               r_dv2;
  logic [ROM_LAT-1:0] r_dv_d;
  logic [ROM_LAT-1:0] r_new_d;
  logic [ROM_LAT-1:0] r_wrap_d;
  logic [ADDR_W-1:0]  r_idx_d [ROM_LAT];
  logic               r_q;
  logic               r_dv_out;
  logic               r_edge;
  logic               r_epoch;
  logic [ADDR_W-1:0]  r_idx;

  logic [PHASE_W:0]   w_sum;
  logic [ADDR_W-1:0]  w_chip;
  logic               w_new;
  logic               w_wrap;
  logic               w_bit;

  assign w_sum = {1'b0, r_phase} + {1'b0, r_freq};

  // Stage 1: frequency register and accumulator. The load is carried into
  // stage 2 so the loaded chip lands in step with the loaded phase sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_freq       <= '0;
      r_phase      <= '0;
      r_carry      <= 1'b0;
      r_dv1        <= 1'b0;
      r_load1      <= 1'b0;
      r_load_chip1 <= '0;
    end else begin
      if (freq_we) r_freq <= freq;
      if (load) begin
        r_phase <= load_phase;
        r_carry <= 1'b0;
      end else if (dv_in) begin
        {r_carry, r_phase} <= w_sum;
      end else begin
        r_carry <= 1'b0;
      end
      r_dv1        <= dv_in;
      r_load1      <= load;
      r_load_chip1 <= load_chip;
    end
  end

  // Stage 2: chip counter.
  code_chip_counter #(
    .ADDR_W   (ADDR_W),
    .CODE_LEN (CODE_LEN)
  ) u_chip_counter (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_dv        (r_dv1),
    .i_carry     (r_carry),
    .i_load      (r_load1),
    .i_load_chip (r_load_chip1),
    .o_chip      (w_chip),
    .o_new_chip  (w_new),
    .o_wrap      (w_wrap)
  );

  assign rom_addr = w_chip;

  // Sideband follows the ROM read so that it meets rom_data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dv2    <= 1'b0;
      r_dv_d   <= '0;
      r_new_d  <= '0;
      r_wrap_d <= '0;
      for (int i = 0; i < ROM_LAT; i++) r_idx_d[i] <= '0;
    end else begin
      r_dv2       <= r_dv1;
      r_dv_d[0]   <= r_dv2;
      r_new_d[0]  <= w_new;
      r_wrap_d[0] <= w_wrap;
      r_idx_d[0]  <= w_chip;
      for (int i = 1; i < ROM_LAT; i++) begin
        r_dv_d[i]   <= r_dv_d[i-1];
        r_new_d[i]  <= r_new_d[i-1];
        r_wrap_d[i] <= r_wrap_d[i-1];
        r_idx_d[i]  <= r_idx_d[i-1];
      end
    end
  end

  assign w_bit = (32'(code_sel) < 32'(NUM_CODES)) ? rom_data[code_sel] : 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q      <= 1'b0;
      r_dv_out <= 1'b0;
      r_edge   <= 1'b0;
      r_epoch  <= 1'b0;
      r_idx    <= '0;
    end else begin
      r_q      <= w_bit;
      r_dv_out <= r_dv_d[ROM_LAT-1];
      r_edge   <= r_dv_d[ROM_LAT-1] & r_new_d[ROM_LAT-1];
      r_epoch  <= r_dv_d[ROM_LAT-1] & r_wrap_d[ROM_LAT-1];
      r_idx    <= r_idx_d[ROM_LAT-1];
    end
  end

  assign q         = r_q;
  assign dv_out    = r_dv_out;
  assign chip_edge = r_edge;
  assign epoch     = r_epoch;
  assign chip_idx  = r_idx;

endmodule

// File: tb/tb_code_nco_ctl.sv
module tb_code_nco_ctl;
  import code_nco_pkg::*;

  localparam logic [31:0] F4 = 32'h4000_0000;
  localparam logic [31:0] F8 = 32'h8000_0000;
  localparam logic [31:0] FF = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        dv_in;
  logic [31:0] freq;
  logic        freq_we;
  logic        load;
  logic [9:0]  load_chip;
  logic [31:0] load_phase;
  logic [5:0]  code_sel;
  logic [9:0]  rom_addr;
  logic [35:0] rom_q;
  logic        dv_out;
  logic        q;
  logic [9:0]  chip_idx;
  logic        chip_edge;
  logic        epoch;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  code_nco_ctl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .dv_in      (dv_in),
    .freq       (freq),
    .freq_we    (freq_we),
    .load       (load),
    .load_chip  (load_chip),
    .load_phase (load_phase),
    .code_sel   (code_sel),
    .rom_addr   (rom_addr),
    .rom_data   (rom_q),
    .dv_out     (dv_out),
    .q          (q),
    .chip_idx   (chip_idx),
    .chip_edge  (chip_edge),
    .epoch      (epoch)
  );

  // Arbitrary but fixed ROM contents; codes beyond CA_NUM_SV read as 0.
  function automatic bit rom_bit(input int a, input int k);
    if (k >= CA_NUM_SV) return 1'b0;
    return ((a * 5 + k * 3) % 7) < 3;
  endfunction

  function automatic logic [35:0] rom_word(input logic [9:0] a);
    logic [35:0] w;
    for (int k = 0; k < 36; k++) w[k] = rom_bit(int'(a), k);
    return w;
  endfunction

  // ROM with one cycle read latency.
  always @(posedge clk) rom_q <= rom_word(rom_addr);

  task automatic chk(input string nm, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
    end
  endtask

  typedef struct {
    bit          rst;
    bit          dv;
    bit          fwe;
    logic [31:0] freq;
    bit          ld;
    logic [9:0]  lchip;
    logic [31:0] lphase;
    logic [5:0]  sel;
    bit          e_dv;
    bit          e_edge;
    bit          e_ep;
    chip_idx_t   e_idx;
  } vec_t;

  vec_t vq[$];

  task automatic row(input bit rst, input bit dv, input bit fwe, input logic [31:0] f,
                     input bit ld, input logic [9:0] lc, input logic [31:0] lp,
                     input logic [5:0] sel, input bit edv, input bit eedge,
                     input bit eep, input logic [9:0] eidx);
    vec_t v;
    v.rst = rst; v.dv = dv; v.fwe = fwe; v.freq = f; v.ld = ld; v.lchip = lc;
    v.lphase = lp; v.sel = sel; v.e_dv = edv; v.e_edge = eedge; v.e_ep = eep;
    v.e_idx = eidx;
    vq.push_back(v);
  endtask

  // Plain valid sample with no writes.
  task automatic smp(input bit dv, input logic [5:0] sel, input bit edv,
                     input bit eedge, input bit eep, input logic [9:0] eidx);
    row(0, dv, 0, 32'h0, 0, 10'd0, 32'h0, sel, edv, eedge, eep, eidx);
  endtask

  task automatic rst_row(input logic [5:0] sel);
    row(1, 0, 0, 32'h0, 0, 10'd0, 32'h0, sel, 0, 0, 0, 10'd0);
  endtask

  initial begin
    vec_t v;
    logic [9:0] pre_idx;

    reset_n = 1'b0; dv_in = 1'b0; freq = '0; freq_we = 1'b0; load = 1'b0;
    load_chip = '0; load_phase = '0; code_sel = '0;

    // Each row: inputs are driven, the next rising edge samples them, and the
    // expected outputs are those seen just after that edge. A sample driven on
    // row j therefore appears on row j+3, four cycles after dv_in was raised.

    // Steady rate: quarter-chip phase steps, a new chip every 4 samples.
    rst_row(5);
    row(0, 0, 1, F4, 0, 0, 0, 5, 0, 0, 0, 0);
    smp(1, 5, 0, 0, 0, 0);   smp(1, 5, 0, 0, 0, 0);   smp(1, 5, 0, 0, 0, 0);
    smp(1, 5, 1, 0, 0, 0);   smp(1, 5, 1, 0, 0, 0);   smp(1, 5, 1, 0, 0, 0);
    smp(1, 5, 1, 1, 0, 1);   smp(1, 5, 1, 0, 0, 1);   smp(1, 5, 1, 0, 0, 1);
    smp(1, 5, 1, 0, 0, 1);   smp(1, 5, 1, 1, 0, 2);   smp(1, 5, 1, 0, 0, 2);

    // Handover load near the end of the code: 1021, 1022, 0, 1.
    rst_row(7);
    row(0, 1, 1, F4, 1, 10'd1021, 32'hC000_0000, 7, 0, 0, 0, 0);
    smp(1, 7, 0, 0, 0, 0);       smp(1, 7, 0, 0, 0, 0);
    smp(1, 7, 1, 1, 0, 10'd1021); smp(1, 7, 1, 1, 0, 10'd1022);
    smp(1, 7, 1, 0, 0, 10'd1022); smp(1, 7, 1, 0, 0, 10'd1022);
    smp(1, 7, 1, 0, 0, 10'd1022); smp(1, 7, 1, 1, 1, 10'd0);
    smp(1, 7, 1, 0, 0, 10'd0);   smp(1, 7, 1, 0, 0, 10'd0);
    smp(1, 7, 1, 0, 0, 10'd0);   smp(1, 7, 1, 1, 0, 10'd1);

    // Gapped samples at half-chip steps; phase must freeze on the gaps.
    rst_row(12);
    row(0, 0, 1, F8, 0, 0, 0, 12, 0, 0, 0, 0);
    smp(1, 12, 0, 0, 0, 0);  smp(0, 12, 0, 0, 0, 0);  smp(1, 12, 0, 0, 0, 0);
    smp(0, 12, 1, 0, 0, 0);  smp(1, 12, 0, 0, 0, 0);  smp(0, 12, 1, 1, 0, 1);
    smp(1, 12, 0, 0, 0, 0);  smp(0, 12, 1, 0, 0, 1);  smp(1, 12, 0, 0, 0, 0);
    smp(0, 12, 1, 1, 0, 2);  smp(1, 12, 0, 0, 0, 0);  smp(0, 12, 1, 0, 0, 2);
    smp(0, 12, 0, 0, 0, 0);  smp(0, 12, 1, 1, 0, 3);

    // Frequency write on a carry-producing sample: that carry uses the old word.
    rst_row(20);
    row(0, 0, 1, F8, 0, 0, 0, 20, 0, 0, 0, 0);
    smp(1, 20, 0, 0, 0, 0);
    row(0, 1, 1, F4, 0, 0, 0, 20, 0, 0, 0, 0);
    smp(1, 20, 0, 0, 0, 0);  smp(1, 20, 1, 0, 0, 0);  smp(1, 20, 1, 1, 0, 1);
    smp(1, 20, 1, 0, 0, 1);  smp(1, 20, 1, 0, 0, 1);  smp(1, 20, 1, 0, 0, 1);
    smp(1, 20, 1, 1, 0, 2);  smp(1, 20, 1, 0, 0, 2);

    // Out-of-range load (1023 is the only such index that fits 10 bits) lands
    // on chip 0; freq_reg stays 0 so the chip holds; select 40 reads as 0.
    rst_row(40);
    row(0, 1, 0, 32'h0, 1, 10'd1023, 32'h0, 40, 0, 0, 0, 0);
    smp(1, 40, 0, 0, 0, 0);  smp(1, 40, 0, 0, 0, 0);  smp(1, 40, 1, 1, 1, 0);
    smp(1, 40, 1, 0, 0, 0);  smp(1, 40, 1, 0, 0, 0);  smp(1, 40, 1, 0, 0, 0);
    smp(1, 40, 1, 0, 0, 0);  smp(1, 40, 1, 0, 0, 0);

    // All-ones word: a carry on every sample after the first.
    rst_row(33);
    row(0, 0, 1, FF, 0, 0, 0, 33, 0, 0, 0, 0);
    smp(1, 33, 0, 0, 0, 0);  smp(1, 33, 0, 0, 0, 0);  smp(1, 33, 0, 0, 0, 0);
    smp(1, 33, 1, 0, 0, 0);  smp(1, 33, 1, 1, 0, 1);  smp(1, 33, 1, 1, 0, 2);
    smp(1, 33, 1, 1, 0, 3);

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      if (v.rst) reset_n = 1'b0;
      dv_in = v.dv; freq_we = v.fwe; freq = v.freq; load = v.ld;
      load_chip = v.lchip; load_phase = v.lphase; code_sel = v.sel;
      @(posedge clk); #1;
      chk("dv_out", i, 32'(dv_out), 32'(v.e_dv));
      chk("chip_edge", i, 32'(chip_edge), 32'(v.e_edge));
      chk("epoch", i, 32'(epoch), 32'(v.e_ep));
      if (v.e_dv) begin
        chk("chip_idx", i, 32'(chip_idx), 32'(v.e_idx));
        chk("q", i, 32'(q), 32'(rom_bit(int'(v.e_idx), int'(v.sel))));
      end
      if (v.rst) begin
        chk("rst_chip_idx", i, 32'(chip_idx), 32'h0);
        chk("rst_q", i, 32'(q), 32'h0);
        chk("rst_rom_addr", i, 32'(rom_addr), 32'h0);
        reset_n = 1'b1;
      end
    end

    // Asynchronous reset in the middle of the all-ones stream.
    load = 1'b0; freq_we = 1'b0; dv_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    pre_idx = chip_idx;
    chk("pre_rst_dv_out", 1000, 32'(dv_out), 32'h1);
    chk("pre_rst_idx_nonzero", 1000, 32'(pre_idx != 10'd0), 32'h1);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("async_dv_out", 1001, 32'(dv_out), 32'h0);
    chk("async_chip_idx", 1001, 32'(chip_idx), 32'h0);
    chk("async_chip_edge", 1001, 32'(chip_edge), 32'h0);
    chk("async_epoch", 1001, 32'(epoch), 32'h0);
    chk("async_q", 1001, 32'(q), 32'h0);
    chk("async_rom_addr", 1001, 32'(rom_addr), 32'h0);
    @(posedge clk); #4;
    reset_n = 1'b1;
    freq_we = 1'b1; freq = F4; dv_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      freq_we = 1'b0;
      if (k < 3) begin
        chk("post_rst_dv_out", 1100 + k, 32'(dv_out), 32'h0);
        chk("post_rst_epoch", 1100 + k, 32'(epoch), 32'h0);
      end else if (k < 7) begin
        chk("post_rst_dv_out", 1100 + k, 32'(dv_out), 32'h1);
        chk("post_rst_idx", 1100 + k, 32'(chip_idx), 32'h0);
        chk("post_rst_edge", 1100 + k, 32'(chip_edge), 32'h0);
        chk("post_rst_q", 1100 + k, 32'(q), 32'(rom_bit(0, 33)));
      end else begin
        chk("post_rst_idx", 1100 + k, 32'(chip_idx),
            chip_wrap_next(0, CA_CODE_LEN));
        chk("post_rst_edge", 1100 + k, 32'(chip_edge), 32'h1);
        chk("post_rst_epoch", 1100 + k, 32'(epoch), 32'h0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
